// File: rtl/bidir_ctrl_pkg.sv
// Shared definitions for the bidirectional pad sequencer: FSM state
// encoding and the width of the shared cycle counter.
package bidir_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        TURN   = 2'd2,
        SAMPLE = 2'd3
    } state_t;

endpackage

// File: rtl/bidir_in_sync.sv
// Per-bit multi-flop synchronizer for the asynchronous pad_o inputs.
// Each bit is synchronized independently, so a multi-bit value that changes
// while it is being sampled may be captured incoherently.
module bidir_in_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    // Shift the pad value through the synchronizer chain; clear on reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_pad_ctrl.sv
// Sequencer for a group of bidirectional pulldown pad cells. Writes drive the
// pads for HOLD_CYCLES cycles, the bus is then released for TURN_CYCLES
// cycles before any read may sample, and reads return synchronized pad data
// as a single-cycle response pulse. Every output comes straight from a flop.
module bidir_pad_ctrl
    import bidir_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 1,
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_t,
    input  logic [WIDTH-1:0] pad_o
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("bidir_pad_ctrl: WIDTH must be 1..32");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("bidir_pad_ctrl: HOLD_CYCLES must be 1..15");
    end
    if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
        $error("bidir_pad_ctrl: TURN_CYCLES must be 1..15");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("bidir_pad_ctrl: SYNC_STAGES must be 2..3");
    end

    // Counter load values: the counter holds "cycles remaining minus one".
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SYNC_STAGES);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic               pending_rd;
    logic               next_pending;
    logic [WIDTH-1:0]   next_drive_data;
    logic               sample_done;
    logic               accept;

    logic               tri_q;
    logic [WIDTH-1:0]   pad_i_q;
    logic               ready_q;
    logic               busy_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic [WIDTH-1:0]   sync_q;

    bidir_in_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK  (CLK),
        .RSTN (RSTN),
        .d    (pad_o),
        .q    (sync_q)
    );

    assign accept = cmd_valid & ready_q;

    // Next-state, counter, pending-read and drive-data decisions.
    always_comb begin
        next_state      = state;
        next_cnt        = cnt;
        next_pending    = pending_rd;
        next_drive_data = pad_i_q;
        sample_done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_write) begin
                        next_state      = DRIVE;
                        next_cnt        = HOLD_LOAD;
                        next_drive_data = cmd_data;
                    end else begin
                        next_state = SAMPLE;
                        next_cnt   = SAMPLE_LOAD;
                    end
                end
            end
            DRIVE: begin
                if (cnt != '0) begin
                    next_cnt = cnt - 1'b1;
                end else if (accept && cmd_write) begin
                    next_cnt        = HOLD_LOAD;
                    next_drive_data = cmd_data;
                end else begin
                    next_state = TURN;
                    next_cnt   = TURN_LOAD;
                    if (accept) begin
                        next_pending = 1'b1;
                    end
                end
            end
            TURN: begin
                if (cnt != '0) begin
                    next_cnt = cnt - 1'b1;
                end else if (pending_rd) begin
                    next_state   = SAMPLE;
                    next_cnt     = SAMPLE_LOAD;
                    next_pending = 1'b0;
                end else begin
                    next_state = IDLE;
                end
            end
            SAMPLE: begin
                if (cnt != '0) begin
                    next_cnt = cnt - 1'b1;
                end else begin
                    next_state  = IDLE;
                    sample_done = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register plus output flops derived from the upcoming state.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state       <= IDLE;
            cnt         <= '0;
            pending_rd  <= 1'b0;
            tri_q       <= 1'b1;
            pad_i_q     <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            pending_rd  <= next_pending;
            tri_q       <= (next_state != DRIVE);
            pad_i_q     <= (next_state == DRIVE) ? next_drive_data : '0;
            ready_q     <= (next_state == IDLE) ||
                           ((next_state == DRIVE) && (next_cnt == '0));
            busy_q      <= (next_state != IDLE);
            rsp_valid_q <= sample_done;
            if (sample_done) begin
                rsp_data_q <= sync_q;
            end
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign pad_t     = {WIDTH{tri_q}};
    assign pad_i     = pad_i_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bidir_pad_ctrl.sv
// Self-checking bench for bidir_pad_ctrl: a directed vector table, a few
// multi-cycle corner sequences and a randomized run, all compared against a
// transaction-level timeline model of the pad bus.
module tb_bidir_pad_ctrl;

    localparam int WIDTH = 8;
    localparam int HOLD  = 1;
    localparam int TURN  = 2;
    localparam int SYNC  = 2;

    logic             CLK;
    logic             RSTN;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic [WIDTH-1:0] pad_i;
    logic [WIDTH-1:0] pad_t;
    logic [WIDTH-1:0] pad_o;
    logic [WIDTH-1:0] ext_drive;

    int tests_run = 0;
    int failures  = 0;
    int cyc       = 0;

    // Pad cell model: released pads show the external agent (0 = pulldown).
    assign pad_o = (pad_t & ext_drive) | (~pad_t & pad_i);

    bidir_pad_ctrl #(
        .WIDTH       (WIDTH),
        .HOLD_CYCLES (HOLD),
        .TURN_CYCLES (TURN),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .pad_i     (pad_i),
        .pad_t     (pad_t),
        .pad_o     (pad_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Timeline model: which cycles drive which data, when responses land.
    logic [WIDTH-1:0] drive_map [int];
    logic [WIDTH-1:0] resp_map  [int];
    int               busy_until;
    int               drive_end;
    logic [WIDTH-1:0] last_rsp;

    function automatic void model_reset();
        drive_map.delete();
        resp_map.delete();
        busy_until = -1;
        drive_end  = -1000;
        last_rsp   = '0;
    endfunction

    function automatic bit model_ready(input int x);
        return (x > busy_until) || (x == drive_end);
    endfunction

    function automatic void model_accept(input int c, input bit wr,
                                         input logic [WIDTH-1:0] d,
                                         input logic [WIDTH-1:0] ext);
        if (wr) begin
            for (int k = 1; k <= HOLD; k++) begin
                drive_map[c+k] = d;
            end
            drive_end  = c + HOLD;
            busy_until = c + HOLD + TURN;
        end else if (c == drive_end) begin
            resp_map[c+TURN+SYNC+2] = ext;
            busy_until = c + TURN + SYNC + 1;
        end else begin
            resp_map[c+SYNC+2] = ext;
            busy_until = c + SYNC + 1;
        end
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Compare all DUT outputs for the current cycle against the model.
    task automatic check_model();
        logic [WIDTH-1:0] exp_t;
        logic [WIDTH-1:0] exp_i;
        bit               exp_rv;
        exp_t  = drive_map.exists(cyc) ? '0 : '1;
        exp_i  = drive_map.exists(cyc) ? drive_map[cyc] : '0;
        exp_rv = resp_map.exists(cyc);
        if (exp_rv) last_rsp = resp_map[cyc];
        check_output("model_pad_t",     32'(pad_t),     32'(exp_t));
        check_output("model_pad_i",     32'(pad_i),     32'(exp_i));
        check_output("model_cmd_ready", 32'(cmd_ready), 32'(model_ready(cyc)));
        check_output("model_busy",      32'(busy),      32'(cyc <= busy_until));
        check_output("model_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check_output("model_rsp_data",  32'(rsp_data),  32'(last_rsp));
    endtask

    // Drive one cycle of inputs, update the model and advance to the next cycle.
    task automatic apply_stimulus(input bit rstn, input bit valid, input bit wr,
                                  input logic [WIDTH-1:0] d,
                                  input logic [WIDTH-1:0] ext);
        RSTN      = rstn;
        cmd_valid = valid;
        cmd_write = wr;
        cmd_data  = d;
        ext_drive = ext;
        if (!rstn) begin
            model_reset();
        end else if (valid && model_ready(cyc)) begin
            model_accept(cyc, wr, d, ext);
        end
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
    endtask

    task automatic step(input bit rstn, input bit valid, input bit wr,
                        input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ext);
        check_model();
        apply_stimulus(rstn, valid, wr, d, ext);
    endtask

    typedef struct {
        bit               rstn;
        bit               valid;
        bit               wr;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] ext;
        bit               e_ready;
        logic [WIDTH-1:0] e_t;
        logic [WIDTH-1:0] e_i;
        bit               e_busy;
        bit               e_rv;
        logic [WIDTH-1:0] e_rd;
    } vec_t;

    vec_t tbl [$];

    initial begin
        logic [WIDTH-1:0] cur_ext;
        bit               r_rstn;
        bit               r_valid;
        bit               r_wr;
        logic [WIDTH-1:0] r_data;

        // Reset, write A5, read idle pulldown, write 3C then immediate read of C3.
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'hA5, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'hA5, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h3C, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 8'hC3, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hC3});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hC3});

        RSTN      = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_data  = '0;
        ext_drive = '0;
        @(posedge CLK);
        @(negedge CLK);
        cyc = 0;
        model_reset();

        $display("[TB] directed vector table");
        foreach (tbl[n]) begin
            check_model();
            check_output("tbl_pad_t",     32'(pad_t),     32'(tbl[n].e_t));
            check_output("tbl_pad_i",     32'(pad_i),     32'(tbl[n].e_i));
            check_output("tbl_cmd_ready", 32'(cmd_ready), 32'(tbl[n].e_ready));
            check_output("tbl_busy",      32'(busy),      32'(tbl[n].e_busy));
            check_output("tbl_rsp_valid", 32'(rsp_valid), 32'(tbl[n].e_rv));
            check_output("tbl_rsp_data",  32'(rsp_data),  32'(tbl[n].e_rd));
            apply_stimulus(tbl[n].rstn, tbl[n].valid, tbl[n].wr,
                           tbl[n].data, tbl[n].ext);
        end

        $display("[TB] back-to-back writes");
        cur_ext = 8'hC3;
        step(1'b1, 1'b1, 1'b1, 8'h01, cur_ext);
        step(1'b1, 1'b1, 1'b1, 8'h02, cur_ext);
        step(1'b1, 1'b1, 1'b1, 8'h03, cur_ext);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 8'h00, cur_ext);

        $display("[TB] idle read with pulldown only");
        cur_ext = 8'h00;
        step(1'b1, 1'b1, 1'b0, 8'h00, cur_ext);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 8'h00, cur_ext);

        $display("[TB] reset during drive, reset with valid");
        step(1'b1, 1'b1, 1'b1, 8'h5A, cur_ext);
        step(1'b0, 1'b0, 1'b0, 8'h00, cur_ext);
        step(1'b1, 1'b0, 1'b0, 8'h00, cur_ext);
        step(1'b0, 1'b1, 1'b1, 8'h77, cur_ext);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 8'h00, cur_ext);

        $display("[TB] reset during sample");
        cur_ext = 8'h81;
        step(1'b1, 1'b1, 1'b0, 8'h00, cur_ext);
        step(1'b1, 1'b0, 1'b0, 8'h00, cur_ext);
        step(1'b0, 1'b0, 1'b0, 8'h00, cur_ext);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 8'h00, cur_ext);

        $display("[TB] write then read after resets");
        step(1'b1, 1'b1, 1'b1, 8'h96, cur_ext);
        cur_ext = 8'h69;
        step(1'b1, 1'b1, 1'b0, 8'h00, cur_ext);
        for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 1'b0, 8'h00, cur_ext);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 800; k++) begin
            r_rstn  = ($urandom_range(0, 63) != 0);
            r_valid = ($urandom_range(0, 9) < 6);
            r_wr    = 1'($urandom_range(0, 1));
            r_data  = WIDTH'($urandom);
            if (r_rstn && r_valid && !r_wr && model_ready(cyc)) begin
                cur_ext = WIDTH'($urandom);
            end
            step(r_rstn, r_valid, r_wr, r_data, cur_ext);
        end
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 8'h00, cur_ext);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
